// File: rtl/pca_seq_pkg.sv
// Shared state encoding and register-map constants for the register write sequencer.
package pca_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BCAST  = 2'd2
   } seq_state_e;

   localparam logic [7:0] LED_BASE     = 8'h06;
   localparam logic [7:0] ALL_LED_BASE = 8'hFA;
   localparam logic [7:0] ALL_LED_LAST = 8'hFD;
   localparam logic [7:0] LED_STRIDE   = 8'd4;

   function automatic logic is_all_led(input logic [7:0] id);
      return (id >= ALL_LED_BASE) && (id <= ALL_LED_LAST);
   endfunction

   // Which of the four per-LED registers (ON_L..OFF_H) the broadcast targets.
   function automatic logic [1:0] all_led_offset(input logic [7:0] id);
      return 2'(id - ALL_LED_BASE);
   endfunction

   function automatic logic [7:0] led_addr(input logic [7:0] n, input logic [1:0] k);
      return LED_BASE + (LED_STRIDE * n) + {6'b000000, k};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Requester arbiter for the register write port: one-hot grant among valid requesters.
// Build option ARB_ROUND_ROBIN_EN: round-robin with a pointer; otherwise fixed priority, lowest index first.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               accept_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant_s;

`ifdef ARB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W-1:0] grant_idx_s;

   // Search upward from the pointer, wrapping, and grant the first valid requester
   always_comb begin
      int   idx_v;
      logic found_v;
      logic hit_v;
      grant_s     = '0;
      grant_idx_s = '0;
      found_v     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_v          = ((int'(ptr_r) + i) >= NUM_REQ) ? (int'(ptr_r) + i - NUM_REQ) : (int'(ptr_r) + i);
         hit_v          = ~found_v & req_i[idx_v];
         grant_s[idx_v] = hit_v;
         grant_idx_s    = hit_v ? PTR_W'(idx_v) : grant_idx_s;
         found_v        = found_v | hit_v;
      end
   end

   // Pointer moves just past the requester that was served
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_r <= '0;
      end else if (accept_i) begin
         ptr_r <= (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (grant_idx_s + PTR_W'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   logic unused_s;

   // Lowest index wins; the I2C target is always served first
   always_comb begin
      logic found_v;
      logic hit_v;
      grant_s = '0;
      found_v = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hit_v      = ~found_v & req_i[i];
         grant_s[i] = hit_v;
         found_v    = found_v | hit_v;
      end
   end

   assign unused_s = ^{clk_i, rst_i, accept_i};
`endif

   assign grant_o = grant_s;

endmodule

// File: rtl/reg_write_sequencer.sv
// Sole owner of the register store write port: arbitrates requesters and expands ALL_LED writes.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration (fixed priority when undefined).
module reg_write_sequencer
   import pca_seq_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int LED_COUNT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_id_i,
   input  logic [NUM_REQ*8-1:0] req_value_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           write_register_id_o,
   output logic [7:0]           write_register_value_o,
   output logic                 write_enable_o,
   output logic                 busy_o
);

   localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

   seq_state_e          state_r;
   seq_state_e          next_state_s;
   logic [NUM_REQ-1:0]  grant_s;
   logic                open_s;
   logic                accept_s;
   logic [7:0]          sel_id_s;
   logic [7:0]          sel_val_s;
   logic [1:0]          sel_k_s;
   logic [IDX_W-1:0]    led_idx_r;
   logic [IDX_W-1:0]    led_idx_nxt_s;
   logic [IDX_W-1:0]    idx_inc_s;
   logic                last_led_s;
   logic [1:0]          k_r;
   logic [1:0]          k_nxt_s;
   logic [7:0]          wr_id_r;
   logic [7:0]          wr_id_nxt_s;
   logic [7:0]          wr_val_r;
   logic [7:0]          wr_val_nxt_s;
   logic                wr_en_r;
   logic                wr_en_nxt_s;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_valid_i),
      .accept_i (accept_s),
      .grant_o  (grant_s)
   );

   // Ready is withheld during flush and while reset is asserted so nothing is accepted then
   assign open_s      = (state_r == IDLE) & ~flush_i & ~rst_i;
   assign req_ready_o = grant_s & {NUM_REQ{open_s}};
   assign accept_s    = |(req_ready_o & req_valid_i);
   assign sel_k_s     = all_led_offset(sel_id_s);
   assign idx_inc_s   = led_idx_r + IDX_W'(1);
   assign last_led_s  = (led_idx_r == IDX_W'(LED_COUNT - 1));

   // One-hot mux of the granted requester's id and value
   always_comb begin
      sel_id_s  = 8'h00;
      sel_val_s = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_id_s  = sel_id_s  | (req_id_i[i*8 +: 8]    & {8{grant_s[i]}});
         sel_val_s = sel_val_s | (req_value_i[i*8 +: 8] & {8{grant_s[i]}});
      end
   end

   // State register and registered store-port outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         led_idx_r <= '0;
         k_r       <= 2'b00;
         wr_id_r   <= 8'h00;
         wr_val_r  <= 8'h00;
         wr_en_r   <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         led_idx_r <= led_idx_nxt_s;
         k_r       <= k_nxt_s;
         wr_id_r   <= wr_id_nxt_s;
         wr_val_r  <= wr_val_nxt_s;
         wr_en_r   <= wr_en_nxt_s;
      end
   end

   // Next-state decision
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = is_all_led(sel_id_s) ? BCAST : SINGLE;
            end else begin
               next_state_s = IDLE;
            end
         end
         SINGLE: next_state_s = IDLE;
         BCAST: begin
            if (flush_i || last_led_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = BCAST;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Next write strobe: the strobe for cycle N+1 is prepared while accepting in cycle N
   always_comb begin
      wr_en_nxt_s   = 1'b0;
      wr_id_nxt_s   = wr_id_r;
      wr_val_nxt_s  = wr_val_r;
      led_idx_nxt_s = '0;
      k_nxt_s       = k_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               wr_en_nxt_s  = 1'b1;
               wr_val_nxt_s = sel_val_s;
               k_nxt_s      = sel_k_s;
               wr_id_nxt_s  = is_all_led(sel_id_s) ? led_addr(8'h00, sel_k_s) : sel_id_s;
            end else begin
               wr_en_nxt_s = 1'b0;
            end
         end
         SINGLE: wr_en_nxt_s = 1'b0;
         BCAST: begin
            if (flush_i || last_led_s) begin
               wr_en_nxt_s = 1'b0;
            end else begin
               wr_en_nxt_s   = 1'b1;
               led_idx_nxt_s = idx_inc_s;
               wr_id_nxt_s   = led_addr(8'(idx_inc_s), k_r);
            end
         end
         default: wr_en_nxt_s = 1'b0;
      endcase
   end

   assign write_register_id_o    = wr_id_r;
   assign write_register_value_o = wr_val_r;
   assign write_enable_o         = wr_en_r;
   assign busy_o                 = (state_r != IDLE);

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer: expected store writes are queued by the stimulus and
// checked by an independent monitor whenever write_enable_o strobes.
module tb_reg_write_sequencer;

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] val;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_id = 16'h0000;
   logic [15:0] req_value = 16'h0000;
   logic [1:0]  ready;
   logic [7:0]  wid;
   logic [7:0]  wval;
   logic        we;
   logic        busy;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass = 0;
   int  exp_r[4];

   always #5 clk = ~clk;

   reg_write_sequencer #(.NUM_REQ(2), .LED_COUNT(16)) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .flush_i                (flush),
      .req_valid_i            (req_valid),
      .req_id_i               (req_id),
      .req_value_i            (req_value),
      .req_ready_o            (ready),
      .write_register_id_o    (wid),
      .write_register_value_o (wval),
      .write_enable_o         (we),
      .busy_o                 (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Offer a request and hold it until the DUT accepts it (bounded)
   task automatic issue(input int r, input logic [7:0] id, input logic [7:0] val);
      bit got;
      req_id[r*8 +: 8]    = id;
      req_value[r*8 +: 8] = val;
      req_valid[r]        = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (ready[r]) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL accept_timeout: requester %0d id 0x%0h never accepted", r, id);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin
      if (!rst && we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got id 0x%0h value 0x%0h, expected no write", wid, wval);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_id", {24'h0, wid}, {24'h0, e.id});
            check("write_value", {24'h0, wval}, {24'h0, e.val});
         end
      end
   end

   initial begin
      int got;

      // Reset state, including ready withheld while reset is held
      req_valid = 2'b01;
      #2;
      check("rst_we", {31'h0, we}, 32'h0);
      check("rst_id", {24'h0, wid}, 32'h0);
      check("rst_value", {24'h0, wval}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_ready", {30'h0, ready}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b00;
      sync();

      // Single write and its latency
      issue(0, 8'h00, 8'h10);
      exp_q.push_back({8'h00, 8'h10});
      @(negedge clk);
      check("single_we", {31'h0, we}, 32'h1);
      check("single_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      check("single_we_after", {31'h0, we}, 32'h0);
      check("single_busy_after", {31'h0, busy}, 32'h0);
      sync();

      // 0xFF is not a broadcast: plain pass-through
      issue(1, 8'hFF, 8'h5A);
      exp_q.push_back({8'hFF, 8'h5A});
      @(negedge clk);
      check("ff_we", {31'h0, we}, 32'h1);
      sync();

      // Broadcast k=2 with requester 1 blocked for its whole duration
      issue(0, 8'hFC, 8'h80);
      for (int n = 0; n < 16; n++) exp_q.push_back({8'(8'h08 + 4 * n), 8'h80});
      req_id[15:8]    = 8'h33;
      req_value[15:8] = 8'h44;
      req_valid[1]    = 1'b1;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         check("bcast_ready1_blocked", {31'h0, ready[1]}, 32'h0);
         check("bcast_busy", {31'h0, busy}, 32'h1);
      end
      @(negedge clk);
      check("bcast_busy_done", {31'h0, busy}, 32'h0);
      check("blocked_ready1", {31'h0, ready[1]}, 32'h1);
      exp_q.push_back({8'h33, 8'h44});
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("blocked_write_we", {31'h0, we}, 32'h1);
      sync();

      // Broadcast k=0 from requester 1, flushed during strobe n=5
      issue(1, 8'hFA, 8'h21);
      for (int n = 0; n < 6; n++) exp_q.push_back({8'(8'h06 + 4 * n), 8'h21});
      repeat (5) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_we", {31'h0, we}, 32'h0);
      check("flush_busy", {31'h0, busy}, 32'h0);
      sync();

      // Contention with both requesters continuously valid
`ifdef ARB_ROUND_ROBIN_EN
      exp_r = '{0, 1, 0, 1};
`else
      exp_r = '{0, 0, 0, 0};
`endif
      req_id    = {8'h02, 8'h01};
      req_value = {8'hB0, 8'hA0};
      req_valid = 2'b11;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         if (ready != 2'b00) begin
            check("contention_grant", {30'h0, ready}, 32'h1 << exp_r[got]);
            exp_q.push_back((exp_r[got] == 0) ? {8'h01, 8'hA0} : {8'h02, 8'hB0});
            got++;
            if (got == 4) begin
               @(posedge clk);
               #1;
               req_valid[0] = 1'b0;
            end
         end
      end
      if (got < 4) begin
         n_checks++;
         $display("FAIL contention_timeout: got %0d grants, expected 4", got);
         req_valid[0] = 1'b0;
      end
      issue(1, 8'h02, 8'hB0);
      exp_q.push_back({8'h02, 8'hB0});
      repeat (2) @(negedge clk);
      sync();

      // Reset pulse in the middle of a k=3 broadcast
      issue(0, 8'hFD, 8'h77);
      exp_q.push_back({8'h09, 8'h77});
      exp_q.push_back({8'h0D, 8'h77});
      @(posedge clk);
      @(posedge clk);
      #2;
      req_id[7:0]    = 8'h00;
      req_value[7:0] = 8'h10;
      req_valid[0]   = 1'b1;
      rst = 1'b1;
      #1;
      check("midrst_we", {31'h0, we}, 32'h0);
      check("midrst_id", {24'h0, wid}, 32'h0);
      check("midrst_value", {24'h0, wval}, 32'h0);
      check("midrst_ready", {30'h0, ready}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b00;
      sync();
      issue(0, 8'h00, 8'h10);
      exp_q.push_back({8'h00, 8'h10});
      @(negedge clk);
      check("postrst_we", {31'h0, we}, 32'h1);
      check("postrst_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      check("postrst_we_after", {31'h0, we}, 32'h0);
      check("postrst_busy_after", {31'h0, busy}, 32'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
